// File: rtl/mult_hilo_sequencer.sv
// mult_hilo_sequencer
//   Sequences a shared multi-cycle signed multiplier for the MIPS core. It
//   accepts a MULT from EX, drives operands and a start pulse, and waits for
//   the multiplier's valid flag. The product lands in HI/LO. The block also
//   serves MFHI/MFLO/MTHI/MTLO, and it stalls those instructions while a
//   multiply is in flight.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     MULT handshake from EX; req_a/req_b are signed operands
//   flush                   cancels an in-flight MULT and blocks acceptance in IDLE
//   rd_en, rd_sel, rd_data  MFHI/MFLO; rd_sel 0 = LO, 1 = HI; rd_data is combinational
//   wr_en, wr_data          MTHI/MTLO; the target register is chosen by rd_sel
//   stall                   hold the HI/LO instruction while busy
//   busy                    multiply sequence in progress
//   err, err_clr            sticky multiplier-timeout flag and its clear
//   mul_a, mul_b, mul_start operands and start pulse to the multiplier
//   mul_result, mul_valid   product (2*WIDTH) and valid flag from the multiplier
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | HI/LO reads and writes served; a MULT can be accepted
// START  | one-cycle mul_start pulse; the multiplier restarts
// RUN    | waiting for mul_valid, bounded by TIMEOUT cycles

module mult_hilo_sequencer #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 40
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   input  logic               flush,
   input  logic               rd_en,
   input  logic               rd_sel,
   output logic [WIDTH-1:0]   rd_data,
   input  logic               wr_en,
   input  logic [WIDTH-1:0]   wr_data,
   output logic               stall,
   output logic               busy,
   output logic               err,
   input  logic               err_clr,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   output logic               mul_start,
   input  logic [2*WIDTH-1:0] mul_result,
   input  logic               mul_valid
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      cnt_d   = cnt_q;
      // A timeout in the same cycle overrides err_clr, because it is assigned later.
      err_d   = err_clr ? 1'b0 : err_q;

      case (state_q)
         S_IDLE: begin
            // A write and an accept can happen in the same cycle. The write
            // lands now, and the multiply overwrites HI/LO when it completes.
            if (wr_en) begin
               if (rd_sel) hi_d = wr_data;
               else        lo_d = wr_data;
            end
            if (req_valid && !flush) begin
               mul_a_d = req_a;
               mul_b_d = req_b;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = flush ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (mul_valid) begin
               hi_d    = mul_result[2*WIDTH-1:WIDTH];
               lo_d    = mul_result[WIDTH-1:0];
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign req_ready = (state_q == S_IDLE);
   assign mul_start = (state_q == S_START);
   assign stall     = busy && (rd_en || wr_en);
   assign rd_data   = rd_sel ? hi_q : lo_q;
   assign err       = err_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_hilo_sequencer.sv
module tb_mult_hilo_sequencer;

   localparam int W  = 16;
   localparam int TO = 40;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready;
   logic [W-1:0]  req_a, req_b;
   logic          flush, rd_en, rd_sel, wr_en, err_clr;
   logic [W-1:0]  rd_data, wr_data, mul_a, mul_b;
   logic          stall, busy, err, mul_start, mul_valid;
   logic [2*W-1:0] mul_result;

   mult_hilo_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .flush(flush),
      .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data),
      .wr_en(wr_en), .wr_data(wr_data),
      .stall(stall), .busy(busy),
      .err(err), .err_clr(err_clr),
      .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
      .mul_result(mul_result), .mul_valid(mul_valid)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference state
   logic [W-1:0] hi_m = '0, lo_m = '0;
   logic         err_m = 1'b0;

   // scoreboard queues
   logic [31:0] exp_ops[$];
   int          exp_busy[$];
   logic [W-1:0] exp_rd[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endfunction

   // monitor
   int bcnt = 0;
   always @(negedge clk) begin
      if (mul_start) begin
         if (exp_ops.size() == 0) chk("start_unexpected", 32'(mul_start), 32'd0);
         else chk("operands", {mul_a, mul_b}, exp_ops.pop_front());
      end
      if (busy) bcnt++;
      else if (bcnt > 0) begin
         if (exp_busy.size() == 0) chk("busy_unexpected", 32'(bcnt), 32'd0);
         else chk("busy_len", 32'(bcnt), 32'(exp_busy.pop_front()));
         bcnt = 0;
      end
      if (rd_en && !stall) begin
         if (exp_rd.size() == 0) chk("read_unexpected", 32'(rd_data), 32'hDEAD_BEEF);
         else chk("read_data", 32'(rd_data), 32'(exp_rd.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input logic sel);
      rd_en  = 1'b1;
      rd_sel = sel;
      exp_rd.push_back(sel ? hi_m : lo_m);
      tick();
      rd_en = 1'b0;
   endtask

   task automatic do_write(input logic sel, input logic [W-1:0] d);
      wr_en   = 1'b1;
      rd_sel  = sel;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      if (sel) hi_m = d; else lo_m = d;
   endtask

   // mode 0: mul_valid in RUN cycle k; 1: flush+mul_valid in RUN cycle k;
   // 2: no valid (timeout); 3: flush during START.
   // side 0: none; 1: read on accept cycle; 2: write HI=1234 on accept cycle.
   task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mode, input int k, input int side,
                          input bit junk, input bit hold_clr);
      int sa, sb, p, n;
      logic [31:0] prod;
      sa = int'($signed(a));
      sb = int'($signed(b));
      p  = sa * sb;
      prod = p;
      exp_ops.push_back({a, b});
      req_valid = 1'b1;
      req_a = a;
      req_b = b;
      if (side == 1) begin
         rd_en  = 1'b1;
         rd_sel = 1'($urandom_range(0, 1));
         exp_rd.push_back(rd_sel ? hi_m : lo_m);
      end else if (side == 2) begin
         wr_en   = 1'b1;
         rd_sel  = 1'b1;
         wr_data = 16'h1234;
      end
      tick();
      if (side == 2) hi_m = 16'h1234;
      req_valid = 1'b0;
      rd_en = 1'b0;
      wr_en = 1'b0;
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      // START cycle
      if (junk) begin
         mul_valid  = 1'b1;
         mul_result = $urandom;
      end
      if (mode == 3) flush = 1'b1;
      rd_sel = 1'b1;
      #1 chk("start_hi_view", 32'(rd_data), 32'(hi_m));
      tick();
      mul_valid = 1'b0;
      flush = 1'b0;
      n = (mode == 3) ? 0 : (mode == 2) ? TO : k;
      for (int i = 1; i <= n; i++) begin
         mul_valid  = 1'b0;
         mul_result = $urandom;
         rd_en   = 1'($urandom_range(0, 1));
         rd_sel  = 1'($urandom_range(0, 1));
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_data = 16'($urandom);
         if (hold_clr) err_clr = 1'b1;
         if (i == n && mode == 0) begin
            mul_valid  = 1'b1;
            mul_result = prod;
         end
         if (i == n && mode == 1) begin
            mul_valid = 1'b1;
            flush     = 1'b1;
         end
         #1;
         if (rd_en || wr_en) chk("stall_busy", 32'(stall), 32'd1);
         chk("rd_hold", 32'(rd_data), 32'(rd_sel ? hi_m : lo_m));
         if (hold_clr) err_m = 1'b0;
         tick();
      end
      rd_en = 1'b0; wr_en = 1'b0; mul_valid = 1'b0; flush = 1'b0; err_clr = 1'b0;
      exp_busy.push_back(1 + n);
      if (mode == 0) begin
         hi_m = prod[31:16];
         lo_m = prod[15:0];
      end
      if (mode == 2) err_m = 1'b1;
      chk("idle_after", 32'(busy), 32'd0);
      chk("err_after", 32'(err), 32'(err_m));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 0; req_a = 0; req_b = 0; flush = 0; rd_en = 0; rd_sel = 0;
      wr_en = 0; wr_data = 0; err_clr = 0; mul_valid = 0; mul_result = 0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_start", 32'(mul_start), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ops", {mul_a, mul_b}, 32'd0);
      rd_en = 1'b1; rd_sel = 1'b1;
      #1 chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_rd_hi", 32'(rd_data), 32'd0);
      rd_en = 1'b0; rd_sel = 1'b0;
      #1 chk("rst_rd_lo", 32'(rd_data), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 3 x -5, valid on the 17th RUN cycle (busy 18 cycles)
      do_mult(16'd3, 16'hFFFB, 0, 17, 0, 0, 0);
      do_read(1'b0);
      do_read(1'b1);
      chk("lo_fff1", 32'(lo_m), 32'h0000_FFF1);

      // flush with mul_valid in RUN cycle 5
      do_mult(16'h0102, 16'h0304, 1, 5, 0, 0, 0);
      do_read(1'b0);
      do_read(1'b1);

      // timeout, then clear
      do_mult(16'h7FFF, 16'h7FFF, 2, 0, 0, 1, 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0; err_m = 1'b0;
      chk("err_cleared", 32'(err), 32'd0);
      // timeout with err_clr held: timeout wins
      do_mult(16'h8000, 16'h8000, 2, 0, 0, 0, 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0; err_m = 1'b0;

      // write HI with request in the same cycle
      do_mult(16'h8000, 16'h7FFF, 0, 3, 2, 0, 0);
      do_read(1'b1);
      do_read(1'b0);

      // flush in IDLE blocks acceptance
      req_valid = 1'b1; flush = 1'b1; req_a = 16'h1111; req_b = 16'h2222;
      tick();
      req_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_busy", 32'(busy), 32'd0);
      chk("idle_flush_ready", 32'(req_ready), 32'd1);

      // valid at the timeout boundary still captures
      do_mult(16'h8000, 16'h8000, 0, TO, 1, 1, 0);
      do_read(1'b1);

      for (int it = 0; it < 30; it++) begin
         int m, kk, sd;
         m  = $urandom_range(0, 9);
         m  = (m < 6) ? 0 : (m < 8) ? 1 : (m < 9) ? 3 : 2;
         kk = $urandom_range(1, TO);
         sd = $urandom_range(0, 1);
         do_mult(16'($urandom), 16'($urandom), m, kk, sd, 1'($urandom_range(0, 1)), 0);
         if (err_m) begin
            err_clr = 1'b1; tick(); err_clr = 1'b0; err_m = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) begin
            mul_valid = 1'b1; mul_result = $urandom;
            tick();
            mul_valid = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) do_write(1'($urandom_range(0, 1)), 16'($urandom));
         do_read(1'b0);
         do_read(1'b1);
      end

      // reset in the middle of RUN
      do_write(1'b1, 16'hBEEF);
      exp_ops.push_back({16'h0005, 16'h0007});
      req_valid = 1'b1; req_a = 16'h0005; req_b = 16'h0007;
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      exp_busy.push_back(3);
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_start", 32'(mul_start), 32'd0);
      rd_sel = 1'b1; rd_en = 1'b1;
      #1 chk("mid_rst_hi", 32'(rd_data), 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      rd_en = 1'b0; rd_sel = 1'b0;
      #1 chk("mid_rst_lo", 32'(rd_data), 32'd0);
      hi_m = '0; lo_m = '0; err_m = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      do_read(1'b1);
      do_read(1'b0);
      do_mult(16'hFFFF, 16'hFFFF, 0, 2, 0, 0, 0);
      do_read(1'b0);
      tick(); tick();

      chk("ops_drained", 32'(exp_ops.size()), 32'd0);
      chk("busy_drained", 32'(exp_busy.size()), 32'd0);
      chk("reads_drained", 32'(exp_rd.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
